// File: rtl/audio_clkgen_if.sv
// Signal bundle for the audio clock generator: run/mode controls in, clocks, strobes and
// frame position out, plus the FSM state for observation.
interface audio_clkgen_if #(
    parameter int W         = 9,
    parameter int SLOT_LOG2 = 1
);
    // en/mode are level controls sampled on every rising clock edge; no handshake, and
    // every output is valid for the whole cycle that follows the edge that produced it.
    logic                 en;
    logic [1:0]           mode;
    logic                 mclk;
    logic                 sclk;
    logic                 lrck;
    logic [W-1:0]         seq;
    logic [SLOT_LOG2-1:0] slot;
    logic                 bit_stb;
    logic                 frame_stb;
    logic                 busy;
    logic [1:0]           state;

    modport master (
        output en, mode,
        input  mclk, sclk, lrck, seq, slot, bit_stb, frame_stb, busy, state
    );

    modport slave (
        input  en, mode,
        output mclk, sclk, lrck, seq, slot, bit_stb, frame_stb, busy, state
    );
endinterface

// File: rtl/audio_clkgen.sv
// Audio clock generator: one free-running frame counter produces mclk, sclk, lrck and
// strobes; a drain state lets the last frame finish cleanly after en drops.
module audio_clkgen #(
    parameter int MCLK_BIT       = 0,
    parameter int SCLK_BIT       = 2,
    parameter int SLOT_BITS_LOG2 = 5,
    parameter int SLOT_LOG2      = 1
) (
    input  logic       i_clock,
    input  logic       i_reset,
    audio_clkgen_if.slave bus
);
    localparam int W = SCLK_BIT + 1 + SLOT_BITS_LOG2 + SLOT_LOG2;
    localparam logic [W-1:0] LEAD = W'(1) << (SCLK_BIT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_seq;
    logic [W-1:0]   w_seq_nxt;
    logic [1:0]     r_mode_q;
    logic [1:0]     w_mode_nxt;
    logic           w_wrap;
    logic           w_running;
    logic [W-1:0]   w_seq_lead;
    logic           w_lrck;

    logic                 r_mclk;
    logic                 r_sclk;
    logic                 r_lrck;
    logic [SLOT_LOG2-1:0] r_slot;
    logic                 r_bit_stb;
    logic                 r_frame_stb;

    assign w_wrap     = (r_seq == {W{1'b1}});
    assign w_running  = (r_state != S_IDLE);
    assign w_seq_lead = r_seq + LEAD;

    always_comb begin
        w_state_nxt = r_state;
        w_seq_nxt   = r_seq;
        w_mode_nxt  = r_mode_q;
        case (r_state)
            S_IDLE: begin
                w_seq_nxt = '0;
                if (bus.en) begin
                    w_state_nxt = S_RUN;
                    w_mode_nxt  = bus.mode;
                end
            end
            S_RUN: begin
                w_seq_nxt = r_seq + 1'b1;
                // A new format only ever starts on a frame boundary.
                if (w_wrap) w_mode_nxt = bus.mode;
                if (!bus.en) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_seq_nxt = r_seq + 1'b1;
                if (bus.en) begin
                    w_state_nxt = S_RUN;
                end else if (w_wrap) begin
                    w_state_nxt = S_IDLE;
                    w_seq_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_seq_nxt   = '0;
            end
        endcase
    end

    // Mode 1 leads mode 0 by one sclk period; mode 2 is a one-sclk pulse at frame start.
    always_comb begin
        w_lrck = r_seq[W-1];
        case (r_mode_q)
            2'd1:    w_lrck = w_seq_lead[W-1];
            2'd2:    w_lrck = (r_seq[W-1:SCLK_BIT+1] == '0);
            default: w_lrck = r_seq[W-1];
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_seq       <= '0;
            r_mode_q    <= 2'd0;
            r_mclk      <= 1'b0;
            r_sclk      <= 1'b0;
            r_lrck      <= 1'b0;
            r_slot      <= '0;
            r_bit_stb   <= 1'b0;
            r_frame_stb <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_seq    <= w_seq_nxt;
            r_mode_q <= w_mode_nxt;
            // Outputs follow the counter of the previous cycle, so the final drain frame
            // still emits its last position before everything returns to zero.
            if (w_running) begin
                r_mclk      <= r_seq[MCLK_BIT];
                r_sclk      <= r_seq[SCLK_BIT];
                r_lrck      <= w_lrck;
                r_slot      <= r_seq[W-1 -: SLOT_LOG2];
                r_bit_stb   <= (r_seq[SCLK_BIT:0] == '1);
                r_frame_stb <= (r_seq == '0);
            end else begin
                r_mclk      <= 1'b0;
                r_sclk      <= 1'b0;
                r_lrck      <= 1'b0;
                r_slot      <= '0;
                r_bit_stb   <= 1'b0;
                r_frame_stb <= 1'b0;
            end
        end
    end

    assign bus.mclk      = r_mclk;
    assign bus.sclk      = r_sclk;
    assign bus.lrck      = r_lrck;
    assign bus.seq       = r_seq;
    assign bus.slot      = r_slot;
    assign bus.bit_stb   = r_bit_stb;
    assign bus.frame_stb = r_frame_stb;
    assign bus.busy      = w_running;
    assign bus.state     = r_state;
endmodule

// File: tb/tb_audio_clkgen.sv
// Directed bench for audio_clkgen at default parameters (W=9, 512-clock frame): a vector
// table of output snapshots at chosen frame positions, plus reset/drain/mode sequences.
module tb_audio_clkgen;
    logic clk;
    logic rst_n;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    audio_clkgen_if #(.W(9), .SLOT_LOG2(1)) bus ();

    audio_clkgen dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Snapshot fields: {mclk, sclk, lrck, bit_stb, frame_stb, slot}
    typedef struct {
        logic [1:0] mode;
        logic [8:0] at;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [5:0] snap();
        return {bus.mclk, bus.sclk, bus.lrck, bus.bit_stb, bus.frame_stb, bus.slot};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic run_to(input logic [8:0] target);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.seq !== target && n < 1000);
        if (bus.seq !== target) check("run_to_timeout", 32'(bus.seq), 32'(target));
    endtask

    task automatic start(input logic [1:0] m);
        bus.en = 1'b0;
        rst_n  = 1'b0;
        step();
        step();
        rst_n    = 1'b1;
        bus.en   = 1'b1;
        bus.mode = m;
        step();
    endtask

    initial begin
        int prev;
        int n;
        int hi;

        rst_n    = 1'b0;
        bus.en   = 1'b1;
        bus.mode = 2'd1;

        vecs[0]  = '{2'd0, 9'd1,   6'b000010};
        vecs[1]  = '{2'd0, 9'd4,   6'b100000};
        vecs[2]  = '{2'd0, 9'd8,   6'b110100};
        vecs[3]  = '{2'd0, 9'd256, 6'b110100};
        vecs[4]  = '{2'd0, 9'd257, 6'b001001};
        vecs[5]  = '{2'd0, 9'd0,   6'b111101};
        vecs[6]  = '{2'd1, 9'd248, 6'b110100};
        vecs[7]  = '{2'd1, 9'd249, 6'b001000};
        vecs[8]  = '{2'd1, 9'd504, 6'b111101};
        vecs[9]  = '{2'd1, 9'd505, 6'b000001};
        vecs[10] = '{2'd2, 9'd1,   6'b001010};
        vecs[11] = '{2'd2, 9'd8,   6'b111100};
        vecs[12] = '{2'd2, 9'd9,   6'b000000};
        vecs[13] = '{2'd2, 9'd257, 6'b000001};
        vecs[14] = '{2'd3, 9'd257, 6'b001001};

        // Reset held with en high: everything stays zero.
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_outputs", {20'd0, snap(), bus.busy, bus.seq}, 32'd0);
        end
        rst_n  = 1'b1;
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("idle_after_reset", {bus.busy, bus.seq}, 32'd0);
        end
        bus.en   = 1'b1;
        bus.mode = 2'd0;
        step();
        check("start_run", {bus.busy, bus.state, bus.seq}, {20'd0, 1'b1, 2'd1, 9'd0});
        step();
        check("first_frame_stb", {bus.frame_stb, bus.seq}, {22'd0, 1'b1, 9'd1});

        foreach (vecs[i]) begin
            start(vecs[i].mode);
            run_to(vecs[i].at);
            check($sformatf("vec%0d_m%0d_at%0d", i, vecs[i].mode, vecs[i].at),
                  32'(snap()), 32'(vecs[i].exp));
        end

        // Drain after en drops mid-frame.
        start(2'd0);
        run_to(9'd100);
        bus.en = 1'b0;
        n = 0;
        prev = 0;
        do begin
            prev = int'(bus.seq);
            step();
            n++;
        end while (bus.busy && n < 1000);
        check("drain_cycles", n, 412);
        check("drain_last_seq", prev, 511);
        check("drain_idle_seq", {bus.busy, bus.seq}, 32'd0);
        check("drain_tail_lrck", {bus.lrck, bus.frame_stb}, 32'b10);
        step();
        check("drain_idle_outputs", {20'd0, snap(), bus.busy, bus.seq}, 32'd0);

        // Re-assert en during drain: no stall across the frame boundary.
        start(2'd0);
        run_to(9'd100);
        bus.en = 1'b0;
        run_to(9'd300);
        check("drain_state", {bus.busy, bus.state}, {29'd0, 1'b1, 2'd2});
        bus.en = 1'b1;
        run_to(9'd511);
        step();
        check("rearm_wrap", {bus.busy, bus.state, bus.seq}, {20'd0, 1'b1, 2'd1, 9'd0});
        step();
        check("rearm_frame_stb", {bus.frame_stb, bus.seq}, {22'd0, 1'b1, 9'd1});

        // Mid-frame mode change waits for the next frame; then reset mid-frame.
        start(2'd0);
        run_to(9'd50);
        bus.mode = 2'd2;
        run_to(9'd257);
        check("mode_hold_lrck", 32'(bus.lrck), 32'd1);
        run_to(9'd0);
        step();
        check("mode2_first_pulse", {bus.frame_stb, bus.lrck}, 32'b11);
        hi = 0;
        for (int i = 0; i < 512; i++) begin
            if (bus.lrck) hi++;
            if (i < 511) step();
        end
        check("mode2_pulse_width", hi, 8);
        run_to(9'd200);
        rst_n = 1'b0;
        step();
        check("reset_midframe", {20'd0, snap(), bus.busy, bus.seq}, 32'd0);
        rst_n = 1'b1;
        bus.en = 1'b0;
        step();
        check("reset_stays_idle", {bus.busy, bus.seq}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
